// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, sequencer states and timing constants for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_DATA_W = 32;
  localparam int ITER_CNT = MDU_DATA_W;
  localparam int MDU_LATENCY = 37;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_e;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mdu_adder32.sv
// mdu_adder32: combinational ripple-carry adder built from full_adder cells
module mdu_adder32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = cin;
  assign cout = c[W];
  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: fixed-latency MULT/MULTU/DIV/DIVU sequencer sharing one ripple adder
module mdu_seq import mdu_pkg::*; #(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);
  localparam int CW = $clog2(ITER_CNT);
  state_e state, next;
  logic [DATA_W-1:0] x, acc_hi, acc_lo, rs_orig, add_a, add_b, sum, b_abs;
  logic [1:0] op_r;
  logic [CW-1:0] cnt;
  logic add_cin, cout, carry, neg_a, neg_q, dz, ge, is_mul, accept, fix_lo, fix_hi;
  assign is_mul = ~op_r[1];
  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy = state inside {S_ABS_A, S_ABS_B, S_ITER, S_FIX_LO, S_FIX_HI};
  assign done = state == S_DONE;
  assign fix_lo = op_r[0] & neg_q;
  assign fix_hi = op_r[0] & (is_mul ? neg_q : neg_a);
  // Division keeps a 33-bit partial remainder: bit 32 is acc_hi's msb after the shift
  assign ge = acc_hi[DATA_W-1] | cout;
  assign b_abs = (op_r[0] && acc_lo[DATA_W-1]) ? sum : acc_lo;
  assign add_a = state != S_ITER ? '0 :
                 is_mul ? acc_hi : {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
  assign add_b = state == S_ABS_A ? ~x :
                 state == S_ITER ? (is_mul ? (acc_lo[0] ? x : '0) : ~x) :
                 state == S_FIX_HI ? ~acc_hi : ~acc_lo;
  assign add_cin = state == S_ITER ? ~is_mul :
                   (state == S_FIX_HI && is_mul) ? carry : 1'b1;
  mdu_adder32 #(.W(DATA_W)) u_add (.a(add_a), .b(add_b), .cin(add_cin), .sum(sum), .cout(cout));
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = start ? S_ABS_A : S_IDLE;
      S_ABS_A:  next = S_ABS_B;
      S_ABS_B:  next = S_ITER;
      S_ITER:   next = cnt == '0 ? S_FIX_LO : S_ITER;
      S_FIX_LO: next = S_FIX_HI;
      S_FIX_HI: next = S_DONE;
      S_DONE:   next = start ? S_ABS_A : S_IDLE;
      default:  next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      rs_orig <= '0;
      op_r <= '0;
      cnt <= '0;
      carry <= 1'b0;
      neg_a <= 1'b0;
      neg_q <= 1'b0;
      dz <= 1'b0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r <= op;
      x <= rs;
      acc_lo <= rt;
      acc_hi <= '0;
      rs_orig <= rs;
      dz <= op[1] && rt == '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_ABS_A: begin
          neg_a <= x[DATA_W-1];
          neg_q <= x[DATA_W-1] ^ acc_lo[DATA_W-1];
          if (op_r[0] && x[DATA_W-1]) x <= sum;
        end
        // Multiply keeps the multiplicand in x; divide moves the dividend to acc_lo and the divisor to x
        S_ABS_B: begin
          acc_lo <= is_mul ? b_abs : x;
          if (!is_mul) x <= b_abs;
          acc_hi <= '0;
          cnt <= CW'(ITER_CNT - 1);
        end
        S_ITER: begin
          if (is_mul) {acc_hi, acc_lo} <= {cout, sum, acc_lo[DATA_W-1:1]};
          else begin
            acc_hi <= ge ? sum : add_a;
            acc_lo <= {acc_lo[DATA_W-2:0], ge};
          end
          cnt <= cnt - 1'b1;
        end
        S_FIX_LO: begin
          if (fix_lo) acc_lo <= sum;
          carry <= cout;
        end
        S_FIX_HI: begin
          hi <= dz ? rs_orig : (fix_hi ? sum : acc_hi);
          lo <= dz ? '1 : acc_lo;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for the multiply/divide sequencer
module tb_mdu_seq;
  import mdu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rs = '0, rt = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  mdu_seq dut (.clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
               .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero));
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int from, output int lat, output bit busy_ok);
    lat = from;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    nvec++; if ({busy, done, div_by_zero} !== 3'b000) begin nerr++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero}); end
    nvec++; if ({hi, lo} !== 64'h0) begin nerr++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    rst = 1'b0;
  endtask
  task automatic test_multu;
    int lat; bit bok;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, lat, bok);
    nvec++; if (lat !== MDU_LATENCY) begin nerr++; $display("FAIL multu_latency got=%0d exp=%0d", lat, MDU_LATENCY); end
    nvec++; if (bok !== 1'b1) begin nerr++; $display("FAIL multu_busy got=%b exp=1", bok); end
    nvec++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin nerr++; $display("FAIL multu_result got=%h exp=fffffffe00000001", {hi, lo}); end
    nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL multu_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    nvec++; if ({busy, done} !== 2'b00) begin nerr++; $display("FAIL multu_pulse got=%b exp=00", {busy, done}); end
  endtask
  task automatic test_mult;
    int lat; bit bok;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done(1, lat, bok);
    nvec++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin nerr++; $display("FAIL mult_neg got=%h exp=fffffffffffffff1", {hi, lo}); end
    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done(1, lat, bok);
    nvec++; if ({hi, lo} !== 64'h40000000_00000000) begin nerr++; $display("FAIL mult_min got=%h exp=4000000000000000", {hi, lo}); end
    nvec++; if (lat !== MDU_LATENCY) begin nerr++; $display("FAIL mult_latency got=%0d exp=%0d", lat, MDU_LATENCY); end
  endtask
  task automatic test_div;
    int lat; bit bok;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, lat, bok);
    nvec++; if ({hi, lo} !== 64'h00000002_0000000E) begin nerr++; $display("FAIL divu got=%h exp=000000020000000e", {hi, lo}); end
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(1, lat, bok);
    nvec++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin nerr++; $display("FAIL div_neg got=%h exp=fffffffffffffffd", {hi, lo}); end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, lat, bok);
    nvec++; if ({div_by_zero, hi, lo} !== {1'b0, 64'h00000000_80000000}) begin nerr++; $display("FAIL div_ovf got=%b_%h exp=0_0000000080000000", div_by_zero, {hi, lo}); end
    issue(OP_DIVU, 32'hFFFFFFFF, 32'h00010000);
    wait_done(1, lat, bok);
    nvec++; if ({hi, lo} !== 64'h0000FFFF_0000FFFF) begin nerr++; $display("FAIL divu_big got=%h exp=0000ffff0000ffff", {hi, lo}); end
  endtask
  task automatic test_div_zero;
    int lat; bit bok;
    issue(OP_DIV, 32'h12345678, 32'd0);
    wait_done(1, lat, bok);
    nvec++; if (lat !== MDU_LATENCY) begin nerr++; $display("FAIL dbz_latency got=%0d exp=%0d", lat, MDU_LATENCY); end
    nvec++; if ({div_by_zero, hi, lo} !== {1'b1, 64'h12345678_FFFFFFFF}) begin nerr++; $display("FAIL dbz_result got=%b_%h exp=1_12345678ffffffff", div_by_zero, {hi, lo}); end
    issue(OP_MULTU, 32'd3, 32'd4);
    nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL dbz_clear got=%b exp=0", div_by_zero); end
    wait_done(1, lat, bok);
    nvec++; if ({div_by_zero, hi, lo} !== {1'b0, 64'h00000000_0000000C}) begin nerr++; $display("FAIL dbz_next got=%b_%h exp=0_000000000000000c", div_by_zero, {hi, lo}); end
  endtask
  task automatic test_ignore_start;
    int lat; bit bok;
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs = 32'd1; rt = 32'd1;
    @(negedge clk);
    start = 1'b0;
    nvec++; if ({busy, hi, lo} !== {1'b1, 64'h00000000_0000000C}) begin nerr++; $display("FAIL hold_prev got=%b_%h exp=1_000000000000000c", busy, {hi, lo}); end
    wait_done(12, lat, bok);
    nvec++; if (lat !== MDU_LATENCY) begin nerr++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, MDU_LATENCY); end
    nvec++; if ({hi, lo} !== 64'h00000000_0000002A) begin nerr++; $display("FAIL ignore_result got=%h exp=000000000000002a", {hi, lo}); end
  endtask
  task automatic test_back_to_back;
    int lat; bit bok;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, lat, bok);
    start = 1'b1; op = OP_MULT; rs = 32'hFFFFFFFD; rt = 32'd5;
    @(negedge clk);
    start = 1'b0;
    nvec++; if ({busy, done} !== 2'b10) begin nerr++; $display("FAIL b2b_accept got=%b exp=10", {busy, done}); end
    wait_done(1, lat, bok);
    nvec++; if (lat !== MDU_LATENCY) begin nerr++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, MDU_LATENCY); end
    nvec++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin nerr++; $display("FAIL b2b_result got=%h exp=fffffffffffffff1", {hi, lo}); end
  endtask
  task automatic test_reset_mid;
    int lat; bit bok, seen;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++; if ({busy, done, hi, lo} !== 66'h0) begin nerr++; $display("FAIL midrst_state got=%b%b_%h exp=00_0", busy, done, {hi, lo}); end
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL midrst_nodone got=%b exp=0", seen); end
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done(1, lat, bok);
    nvec++; if ({lat, hi, lo} !== {MDU_LATENCY, 64'h00000001_FFFFFFFD}) begin nerr++; $display("FAIL midrst_next got=%0d_%h exp=%0d_00000001fffffffd", lat, {hi, lo}, MDU_LATENCY); end
  endtask
  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer for the MIPS core. It executes MULT, MULTU, DIV and DIVU into HI/LO by time-multiplexing a single 32-bit ripple-carry adder built from full_adder cells. It uses a fixed-latency start/busy/done handshake toward the decode/writeback control.

Parameters:
DATA_W, 32, operand width. Only 32 is supported; the iteration count equals DATA_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
rs  input  DATA_W  multiplicand / dividend; sampled with start.
rt  input  DATA_W  multiplier / divisor; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; hi/lo/div_by_zero are valid.
hi  output  DATA_W  HI result (product upper half / remainder).
lo  output  DATA_W  LO result (product lower half / quotient).
div_by_zero  output  1  valid with done; set for DIV/DIVU when rt==0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at an edge: state=IDLE; busy, done, div_by_zero, hi, lo and all internal registers go to 0. This applies mid-operation too; the operation is abandoned with no done.
- State machine: IDLE -> ABS_A -> ABS_B -> ITER (DATA_W cycles, counter DATA_W-1 down to 0) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- Every operation visits every state once; states with nothing to do are no-ops.
- Latency is fixed: start accepted at edge k gives busy=1 for the next 36 cycles and done=1 in the 37th cycle only. busy=0 in IDLE and DONE.
- Start accepted in DONE: moves to ABS_A directly (back-to-back operations). Start in any other non-IDLE state is ignored.
- Shared adder: 32-bit A + B + cin -> sum, cout.
  - Subtract is A + ~B + 1.
  - Negate is 0 + ~X + 1.
- ABS_A / ABS_B: for signed ops, a negative operand is replaced by its negation via the adder; otherwise it is held. The sign of rs and the sign of rs^rt are latched.
- ITER, multiply: if acc_lo[0]=1, {c,acc_hi} = acc_hi + mcand, else {c,acc_hi} = {0,acc_hi}. Then {c,acc_hi,acc_lo} shifts right by 1.
- ITER, divide (restoring): {rem,quo} shifts left by 1, then trial = rem - divisor (33-bit). If trial >= 0, rem=trial and quo[0]=1; else quo[0]=0.
- FIX_LO / FIX_HI, MULT with negative product: 64-bit negate. The low word is negated in FIX_LO, the carry-out is latched, and ~hi + carry is computed in FIX_HI.
- FIX_LO / FIX_HI, DIV: the quotient is negated in FIX_LO if the signs differ. The remainder is negated in FIX_HI if rs was negative, so it takes the dividend's sign.
- FIX_HI is the only state that writes hi and lo. Before that, the outputs hold the previous result.
- Divide by zero (rt==0): full latency still runs. The result is forced to hi=rs (original, unmodified), lo=32'hFFFFFFFF, div_by_zero=1. div_by_zero is 0 for multiplies and is cleared on the next accepted start.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0.
- Width rule: the adder's cout is the 33rd bit in multiply accumulation and the sign of the trial in division. No other adder exists in the block.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - the state enum;
  - localparam ITER_CNT=DATA_W;
  - localparam MDU_LATENCY=37.
- One sub-module, mdu_adder32: a 32-bit ripple adder of full_adder instances with cin/cout, purely combinational. mdu_seq instantiates exactly one.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done exactly 37 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, busy high for 36 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU rs=100 rt=7 -> lo=0x0000000E, hi=0x00000002; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x12345678 rt=0 -> done after 37 cycles, div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF; next MULTU clears div_by_zero.
- Start pulsed during ITER -> ignored, first result unchanged; start held in DONE -> second op begins, its done 37 cycles later.
- rst asserted for one edge in cycle 20 of a DIVU -> busy=0, done=0, hi=lo=0 next cycle, no done pulse; a new op then completes correctly.
